// File: rtl/gray_pkg.sv
// gray_pkg: shared Gray-code helpers and constants for the up/down Gray counter family.
// Latency: n/a (functions and constants only).
// Backpressure: n/a.
package gray_pkg;

  localparam int GRAY_MAX_WIDTH = 16;

  localparam logic MODE_UP   = 1'b1;
  localparam logic MODE_DOWN = 1'b0;

  // Callers zero-extend narrower values into 16 bits and slice the result back down.
  function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Inverse mapping: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(input logic [GRAY_MAX_WIDTH-1:0] g);
    logic [GRAY_MAX_WIDTH-1:0] b;
    b[GRAY_MAX_WIDTH-1] = g[GRAY_MAX_WIDTH-1];
    for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_step_checker.sv
// gray_step_checker: flags any count step whose Gray value changed in more than one bit.
// Latency: err rises one clk after the offending gray value appears; sticky until reset.
// Backpressure: none; observes every cycle.
module gray_step_checker #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_step,
  input  logic [WIDTH-1:0] gray,
  output logic             err
);

  logic [WIDTH-1:0] prev_gray_q, prev_gray_d;
  logic             step_q, step_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] diff;
  int unsigned      ones;

  // Compare the gray captured last cycle with the current one; only count steps are judged.
  always_comb begin
    prev_gray_d = gray;
    step_d      = valid_step;
    err_d       = err_q;
    diff        = prev_gray_q ^ gray;
    ones        = 0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + {31'b0, diff[i]};
    end
    if (step_q && (diff != '0) && (ones != 1)) begin
      err_d = 1'b1;
    end
  end

  // History registers and the sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_gray_q <= '0;
      step_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      prev_gray_q <= prev_gray_d;
      step_q      <= step_d;
      err_q       <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: rtl/gray_updown_counter_n.sv
// gray_updown_counter_n: WIDTH-bit up/down Gray counter with load, enable, wrap/saturate, binary shadow.
// Latency: one clk from inputs to gray/bin/wrapped; tc is combinational from bin and mode.
// Backpressure: none; en=0 holds the count. Defining GRAY_STEP_CHECK_EN adds the sticky err output.
module gray_updown_counter_n
  import gray_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             wrap_en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin,
  output logic             tc,
  output logic             wrapped
`ifdef GRAY_STEP_CHECK_EN
  ,
  output logic             err
`endif
);

  localparam logic [GRAY_MAX_WIDTH-1:0] RST_BIN_FULL  = GRAY_MAX_WIDTH'(RESET_VAL);
  localparam logic [GRAY_MAX_WIDTH-1:0] RST_GRAY_FULL = bin2gray(RST_BIN_FULL);
  localparam logic [WIDTH-1:0]          RST_BIN       = RST_BIN_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0]          RST_GRAY      = RST_GRAY_FULL[WIDTH-1:0];

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrapped_q, wrapped_d;

  // Terminal count: about to leave the range in the current direction.
  assign tc = (mode == MODE_UP) ? (&bin_q) : ~(|bin_q);

  // Next count: load beats enable; at the boundary either wrap (with pulse) or saturate.
  // Gray is derived from the next binary value so the Gray register needs no decode on its output.
  always_comb begin
    bin_d     = bin_q;
    wrapped_d = 1'b0;
    if (load) begin
      bin_d = load_bin;
    end else if (en) begin
      if (!tc) begin
        bin_d = (mode == MODE_UP) ? bin_q + 1'b1 : bin_q - 1'b1;
      end else if (wrap_en) begin
        bin_d     = (mode == MODE_UP) ? '0 : '1;
        wrapped_d = 1'b1;
      end
    end
    gray_d = bin_d ^ (bin_d >> 1);
  end

  // Count, Gray and wrap-pulse registers; reset takes priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q     <= RST_BIN;
      gray_q    <= RST_GRAY;
      wrapped_q <= 1'b0;
    end else begin
      bin_q     <= bin_d;
      gray_q    <= gray_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign bin     = bin_q;
  assign gray    = gray_q;
  assign wrapped = wrapped_q;

`ifdef GRAY_STEP_CHECK_EN
  logic valid_step;

  // A count step is an enabled edge that is neither a load nor a reset.
  assign valid_step = en & ~load & ~reset;

  gray_step_checker #(
    .WIDTH (WIDTH)
  ) u_step_checker (
    .clk        (clk),
    .reset      (reset),
    .valid_step (valid_step),
    .gray       (gray_q),
    .err        (err)
  );
`endif

endmodule
